semaforo_multi_fase: RTL

SEMAFORO_MULTI_FASE -- requirements
Module: semaforo_multi_fase

---
 rtl/semaforo_pkg.sv | 15 +
 rtl/semaforo_temporizador.sv | 30 +++
 rtl/semaforo_multi_fase.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// State encoding shared by the multi-phase traffic-light controller and its bench.
package semaforo_pkg;

    localparam int unsigned EstadoW = 3;

    typedef enum logic [EstadoW-1:0] {
        StTodoRojo = 3'd0,
        StVerde    = 3'd1,
        StAmarillo = 3'd2,
        StPeaton   = 3'd3,
        StDespeje  = 3'd4,
        StDestello = 3'd5
    } estado_t;

endpackage

// File: rtl/semaforo_temporizador.sv
// Phase counter: cleared on request, flags the last cycle of a phase lasting `limite` cycles.
module semaforo_temporizador #(
    parameter int unsigned T_W = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           clr,
    input  logic [T_W-1:0] limite,
    output logic [T_W-1:0] cuenta,
    output logic           fin
);

    logic [T_W-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = clr ? '0 : cuenta_q + T_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;
    assign fin    = (cuenta_q == limite - T_W'(1));

endmodule

// File: rtl/semaforo_multi_fase.sv
// Round-robin multi-approach traffic light with pedestrian phase and flashing-yellow mode.
module semaforo_multi_fase
    import semaforo_pkg::*;
#(
    parameter int unsigned NUM_DIR     = 2,
    parameter int unsigned T_W         = 8,
    parameter int unsigned T_VERDE     = 20,
    parameter int unsigned T_VERDE_MIN = 6,
    parameter int unsigned T_AMARILLO  = 4,
    parameter int unsigned T_ROJO      = 2,
    parameter int unsigned T_PEATON    = 10,
    parameter int unsigned T_DESPEJE   = 3,
    parameter int unsigned T_DESTELLO  = 5
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       IN,
    input  logic                       Modo_Destello,
    output logic [NUM_DIR-1:0]         Rojo,
    output logic [NUM_DIR-1:0]         Verde,
    output logic [NUM_DIR-1:0]         Amarillo,
    output logic                       Pasar_Persona,
    output logic [$clog2(NUM_DIR)-1:0] Dir_Actual,
    output logic [EstadoW-1:0]         Estado_Salida
);

    localparam int unsigned DirW = $clog2(NUM_DIR);

    estado_t        estado_q, estado_d;
    logic [DirW-1:0] dir_q, dir_d;
    logic           ped_q, ped_d;
    logic           parpadeo_q, parpadeo_d;
    logic [T_W-1:0] limite, cuenta;
    logic           fin, clr, entrada;

    semaforo_temporizador #(
        .T_W (T_W)
    ) u_temporizador (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (clr),
        .limite  (limite),
        .cuenta  (cuenta),
        .fin     (fin)
    );

    always_comb begin
        limite = T_W'(T_ROJO);
        case (estado_q)
            StVerde:    limite = T_W'(T_VERDE);
            StAmarillo: limite = T_W'(T_AMARILLO);
            StPeaton:   limite = T_W'(T_PEATON);
            StDespeje:  limite = T_W'(T_DESPEJE);
            StDestello: limite = T_W'(T_DESTELLO);
            default:    limite = T_W'(T_ROJO);
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            StTodoRojo: if (fin) estado_d = ped_q ? StPeaton : StVerde;
            StVerde: begin
                if (fin || (ped_q && cuenta >= T_W'(T_VERDE_MIN - 1))) estado_d = StAmarillo;
            end
            StAmarillo: if (fin) estado_d = StTodoRojo;
            StPeaton:   if (fin) estado_d = StDespeje;
            StDespeje:  if (fin) estado_d = StVerde;
            StDestello: if (!Modo_Destello) estado_d = StTodoRojo;
            default:    estado_d = StTodoRojo;
        endcase
        if (Modo_Destello) estado_d = StDestello;
    end

    assign entrada = (estado_d != estado_q);
    // The flashing phase restarts its own count on every toggle.
    assign clr     = entrada || (estado_q == StDestello && fin);

    always_comb begin
        dir_d = dir_q;
        if (estado_q == StAmarillo && estado_d == StTodoRojo) begin
            dir_d = (dir_q == DirW'(NUM_DIR - 1)) ? '0 : dir_q + DirW'(1);
        end

        // Clearing on WALK entry overrides a same-cycle request.
        ped_d = ped_q;
        if (IN && estado_q != StPeaton) ped_d = 1'b1;
        if (estado_d == StPeaton && estado_q != StPeaton) ped_d = 1'b0;

        parpadeo_d = 1'b0;
        if (estado_d == StDestello) begin
            if (estado_q != StDestello) parpadeo_d = 1'b1;
            else                        parpadeo_d = fin ? ~parpadeo_q : parpadeo_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q <= StTodoRojo;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_q      <= '0;
            ped_q      <= 1'b0;
            parpadeo_q <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            ped_q      <= ped_d;
            parpadeo_q <= parpadeo_d;
        end
    end

    always_comb begin
        Rojo          = '1;
        Verde         = '0;
        Amarillo      = '0;
        Pasar_Persona = 1'b0;
        case (estado_q)
            StVerde: begin
                Rojo[dir_q]  = 1'b0;
                Verde[dir_q] = 1'b1;
            end
            StAmarillo: begin
                Rojo[dir_q]     = 1'b0;
                Amarillo[dir_q] = 1'b1;
            end
            StPeaton:   Pasar_Persona = 1'b1;
            StDestello: begin
                Rojo     = '0;
                Amarillo = parpadeo_q ? '1 : '0;
            end
            default: ;
        endcase
    end

    assign Dir_Actual    = dir_q;
    assign Estado_Salida = estado_q;

endmodule
